// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead FIFO for received words; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: start, LSB-first data, odd parity and stop bit,
// with timeout detection and a show-ahead output FIFO.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        ps2_clk_posedge,
  input  logic                        ps2_data,
  input  logic                        rx_ready,
  input  logic                        clear_overflow,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_valid,
  output logic [1:0]                  err_code,
  output logic                        overflow,
  output logic                        busy
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  ps2_state_t           state;
  ps2_state_t           next_state;
  logic [DATA_BITS-1:0] shreg;
  logic [BCW-1:0]       bit_cnt;
  logic                 parity_bit;
  logic [TCW-1:0]       idle_cnt;
  logic                 timeout;
  logic                 push;
  logic                 pop;
  logic                 err_now;
  logic [1:0]           err_sel;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 drop;

  assign busy     = (state != IDLE);
  assign timeout  = busy && (idle_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign rx_valid = !fifo_empty;
  assign pop      = rx_valid && rx_ready;
  assign drop     = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Timeout overrides any strobe; the stop strobe decides push versus error.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    err_now    = 1'b0;
    err_sel    = ERR_NONE;
    if (timeout) begin
      next_state = IDLE;
      err_now    = 1'b1;
      err_sel    = ERR_TIMEOUT;
    end else if (ps2_clk_posedge) begin
      case (state)
        IDLE: begin
          if (enable && !ps2_data) begin
            next_state = DATA;
          end
        end
        DATA: begin
          if (bit_cnt == BCW'(DATA_BITS - 1)) begin
            next_state = PARITY;
          end
        end
        PARITY: begin
          next_state = STOP;
        end
        STOP: begin
          next_state = IDLE;
          if (!ps2_data) begin
            err_now = 1'b1;
            err_sel = ERR_STOP;
          end else if (!(^{shreg, parity_bit})) begin
            err_now = 1'b1;
            err_sel = ERR_PARITY;
          end else begin
            push = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      idle_cnt   <= '0;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      overflow   <= 1'b0;
    end else begin
      err_valid <= err_now;
      if (err_now) begin
        err_code <= err_sel;
      end
      if (!busy || ps2_clk_posedge) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (ps2_clk_posedge) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {ps2_data, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  parity_bit <= ps2_data;
          default: ;
        endcase
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  ps2_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (shreg),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench: frame-level reference model compared every cycle,
// plus directed frames with hand-computed expectations.
module tb_ps2_frame_receiver;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int T     = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       ps2_clk_posedge;
  logic       ps2_data;
  logic       rx_ready;
  logic       clear_overflow;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       err_valid;
  logic [1:0] err_code;
  logic       overflow;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_on = 1'b0;
  logic ready_level = 1'b0;

  logic [7:0] q[$];
  logic       bits[$];
  logic       m_busy = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_err_valid = 1'b0;
  logic [1:0] m_err_code = 2'b00;
  int         gap = 0;

  ps2_frame_receiver #(
    .DATA_BITS      (N),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .ps2_clk_posedge (ps2_clk_posedge),
    .ps2_data        (ps2_data),
    .rx_ready        (rx_ready),
    .clear_overflow  (clear_overflow),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .fifo_count      (fifo_count),
    .err_valid       (err_valid),
    .err_code        (err_code),
    .overflow        (overflow),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic oddPar(input logic [7:0] d);
    return ~^d;
  endfunction

  // Reference model: collects the bits of a frame, judges it as a whole.
  task automatic modelStep();
    logic [7:0] w;
    int ones;
    if (reset) begin
      q.delete();
      bits.delete();
      m_busy = 1'b0;
      m_ovf = 1'b0;
      m_err_valid = 1'b0;
      m_err_code = 2'b00;
      gap = 0;
      return;
    end
    m_err_valid = 1'b0;
    if (clear_overflow) m_ovf = 1'b0;
    if (q.size() > 0 && rx_ready) void'(q.pop_front());
    if (m_busy) begin
      if (gap == T - 1) begin
        m_busy = 1'b0;
        m_err_valid = 1'b1;
        m_err_code = 2'b11;
      end else if (ps2_clk_posedge) begin
        bits.push_back(ps2_data);
        gap = 0;
        if (bits.size() == N + 2) begin
          m_busy = 1'b0;
          w = '0;
          ones = 0;
          for (int i = 0; i < N; i++) begin
            w[i] = bits[i];
            ones += int'(bits[i]);
          end
          ones += int'(bits[N]);
          if (bits[N+1] == 1'b0) begin
            m_err_valid = 1'b1;
            m_err_code = 2'b10;
          end else if (ones % 2 == 0) begin
            m_err_valid = 1'b1;
            m_err_code = 2'b01;
          end else if (q.size() < DEPTH) begin
            q.push_back(w);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end else begin
        gap++;
      end
    end else if (ps2_clk_posedge && enable && !ps2_data) begin
      m_busy = 1'b1;
      bits.delete();
      gap = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      checkOutput("cmp_rx_valid", rx_valid, q.size() > 0);
      checkOutput("cmp_rx_data", rx_data, (q.size() > 0) ? q[0] : 8'h00);
      checkOutput("cmp_fifo_count", fifo_count, q.size());
      checkOutput("cmp_overflow", overflow, m_ovf);
      checkOutput("cmp_err_valid", err_valid, m_err_valid);
      checkOutput("cmp_err_code", err_code, m_err_code);
      checkOutput("cmp_busy", busy, m_busy);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobeBit(input logic b, input logic pop_now, input logic clr_now);
    ps2_data = b;
    ps2_clk_posedge = 1'b1;
    rx_ready = ready_level | pop_now;
    clear_overflow = clr_now;
    @(posedge clk);
    #1;
    ps2_clk_posedge = 1'b0;
    ps2_data = 1'b1;
    rx_ready = ready_level;
    clear_overflow = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                               input logic pop_stop, input logic clr_stop, input logic drop_en);
    strobeBit(1'b0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < N; i++) begin
      if (drop_en && i == 2) enable = 1'b0;
      strobeBit(data[i], 1'b0, 1'b0);
      idle(3);
    end
    strobeBit(par, 1'b0, 1'b0);
    idle(3);
    strobeBit(stop, pop_stop, clr_stop);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    ps2_clk_posedge = 1'b0;
    ps2_data = 1'b1;
    rx_ready = 1'b0;
    clear_overflow = 1'b0;
    idle(2);
    reset = 1'b0;
    cmp_on = 1'b1;

    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_fifo_count", fifo_count, 3'd0);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_err_valid", err_valid, 1'b0);
    checkOutput("reset_err_code", err_code, 2'b00);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);

    $display("[TB] good frame 0x1C");
    ready_level = 1'b1;
    rx_ready = 1'b1;
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("f1c_rx_valid", rx_valid, 1'b1);
    checkOutput("f1c_rx_data", rx_data, 8'h1C);
    checkOutput("f1c_err_valid", err_valid, 1'b0);
    idle(1);
    checkOutput("f1c_rx_valid_gone", rx_valid, 1'b0);

    $display("[TB] parity error 0xF0");
    applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("par_err_valid", err_valid, 1'b1);
    checkOutput("par_err_code", err_code, 2'b01);
    checkOutput("par_fifo_count", fifo_count, 3'd0);
    idle(1);
    checkOutput("par_err_pulse_end", err_valid, 1'b0);
    checkOutput("par_err_code_held", err_code, 2'b01);

    $display("[TB] stop error beats parity error");
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stop_err_valid", err_valid, 1'b1);
    checkOutput("stop_err_code", err_code, 2'b10);
    idle(2);

    $display("[TB] start bit ignored while disabled");
    enable = 1'b0;
    strobeBit(1'b0, 1'b0, 1'b0);
    checkOutput("disabled_busy", busy, 1'b0);
    idle(2);
    enable = 1'b1;

    $display("[TB] enable dropped mid-frame");
    applyStimulus(8'h3A, oddPar(8'h3A), 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("endrop_rx_valid", rx_valid, 1'b1);
    checkOutput("endrop_rx_data", rx_data, 8'h3A);
    enable = 1'b1;
    idle(2);

    $display("[TB] timeout after three data bits");
    strobeBit(1'b0, 1'b0, 1'b0);
    idle(3);
    strobeBit(1'b1, 1'b0, 1'b0);
    idle(3);
    strobeBit(1'b0, 1'b0, 1'b0);
    idle(3);
    strobeBit(1'b1, 1'b0, 1'b0);
    idle(99);
    checkOutput("to_busy_before", busy, 1'b1);
    checkOutput("to_err_before", err_valid, 1'b0);
    idle(1);
    checkOutput("to_err_valid", err_valid, 1'b1);
    checkOutput("to_err_code", err_code, 2'b11);
    checkOutput("to_busy_after", busy, 1'b0);
    idle(2);

    $display("[TB] overflow with five frames");
    ready_level = 1'b0;
    rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(8'(k), oddPar(8'(k)), 1'b1, 1'b0, k == 5, 1'b0);
      idle(2);
    end
    checkOutput("ovf_count", fifo_count, 3'd4);
    checkOutput("ovf_flag", overflow, 1'b1);
    ready_level = 1'b1;
    rx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("ovf_drain", rx_data, 8'(k));
      idle(1);
    end
    checkOutput("ovf_drained", rx_valid, 1'b0);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    checkOutput("ovf_cleared", overflow, 1'b0);

    $display("[TB] full FIFO with pop at stop strobe");
    ready_level = 1'b0;
    rx_ready = 1'b0;
    for (int k = 8'h11; k <= 8'h14; k++) begin
      applyStimulus(8'(k), oddPar(8'(k)), 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
    end
    checkOutput("pp_count_full", fifo_count, 3'd4);
    applyStimulus(8'h15, oddPar(8'h15), 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pp_count", fifo_count, 3'd4);
    checkOutput("pp_overflow", overflow, 1'b0);
    ready_level = 1'b1;
    rx_ready = 1'b1;
    for (int k = 8'h12; k <= 8'h15; k++) begin
      checkOutput("pp_drain", rx_data, 8'(k));
      idle(1);
    end
    ready_level = 1'b0;
    rx_ready = 1'b0;
    idle(2);

    $display("[TB] reset mid-frame then 0xAA");
    strobeBit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(3);
      strobeBit(1'b1, 1'b0, 1'b0);
    end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err_valid", err_valid, 1'b0);
    idle(2);
    applyStimulus(8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("aa_count", fifo_count, 3'd1);
    checkOutput("aa_rx_data", rx_data, 8'hAA);
    checkOutput("aa_err_valid", err_valid, 1'b0);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
